instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It replaces the combinational control unit, so memory may be wait-stated. It fetches a two-byte instruction through a request/ready handshake, drives the program counter, and sequences register-file and ALU control for one execute cycle per instruction. It also handles jump, conditional-jump and halt.

## Interface
- No parameters; widths fixed (8-bit data/address, 4-bit ALU select, 3-bit register selects).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- memRd  out  1  fetch request; held until accepted.
- memRdy  in  1  memory ready; byte accepted on the cycle where memRd && memRdy.
- memVal  in  8  fetched byte, valid when memRdy.
- pcInc  out  1  one-cycle pulse per accepted byte.
- pcLoad  out  1  one-cycle PC load strobe (jumps).
- pcLoadVal  out  8  jump target.
- zero  in  1  ALU zero flag, sampled in EXEC.
- aluSel  out  4  ALU operation.
- rInSel  out  3  destination register.
- rOutSel  out  3  source register or constant value.
- rInEn, rOutEn, genConst  out  1 each  register write, register read and constant-drive enables.
- step  in  1  single-step advance; active only with SEQ_SINGLE_STEP_EN.
- halted  out  1  high in HALTED state.
- instrCount  out  8  retired-instruction counter; wraps 255→0.

## Operation
- Instruction byte 0 (op):
  - [7:4] aluSel
  - [3] genConst
  - [2:0] rInSel / sub-op
- Instruction byte 1 (arg):
  - [2:0] rOutSel for ALU ops
  - full byte is the target for jumps
- System class op[7:4]=4'hF, sub-op op[2:0]:
  - 000 NOP
  - 001 HALT
  - 010 JMP
  - 011 JZ
  - 1xx treated as NOP
- FSM states and transitions:
  - FETCH_OP: memRd=1; on accept, latch op, go to FETCH_ARG.
  - FETCH_ARG: memRd=1; on accept, latch arg, go to EXEC.
  - EXEC: one cycle, then FETCH_OP.
    - HALT goes to HALTED.
    - With the macro defined, every non-HALT instruction goes to PAUSE.
  - HALTED: terminal until reset. memRd=0, halted=1.
  - PAUSE (macro only): wait for step=1, then FETCH_OP.
- ALU-class EXEC:
  - rInEn=1
  - rOutEn=~op[3], genConst=op[3]
  - aluSel=op[7:4], rInSel=op[2:0], rOutSel=arg[2:0]
- JMP EXEC: pcLoad=1, pcLoadVal=arg.
- JZ EXEC: pcLoad=zero, pcLoadVal=arg.
- NOP / HALT EXEC: no enables.
- Select outputs (aluSel, rInSel, rOutSel, pcLoadVal) always reflect the latched op/arg; they are harmless outside EXEC.
- rInEn, rOutEn, genConst and pcLoad are 0 in every state except EXEC.
- rOutEn and genConst are never both 1.
- pcInc = memRd && memRdy, combinational.
- pcLoad and pcInc never coincide.
- instrCount increments by 1 on every EXEC cycle, including NOP/HALT/JMP; it wraps modulo 256.

## Timing
- Reset (rst low, async) forces:
  - state=FETCH_OP
  - op=arg=8'h00
  - instrCount=0
  - all enables, pcLoad and halted = 0
- memRd=1 from the first clock edge after rst deasserts (FETCH_OP is combinationally requesting).
- Zero-wait memory: 3 cycles per instruction (FETCH_OP, FETCH_ARG, EXEC).
- Each cycle with memRdy=0 during a fetch adds one cycle; memVal is ignored while memRdy=0.
- The jump target takes effect on the next FETCH_OP: the PC updates at the EXEC clock edge.
- Reset asserted mid-fetch or mid-EXEC aborts immediately. Outputs return to reset values asynchronously, and no partial register write completes after the edge.
- memRdy while memRd=0 is ignored.
- step while not in PAUSE is ignored.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - PAUSE state exists; every EXEC except HALT goes to PAUSE.
  - step=1 in PAUSE → FETCH_OP next cycle.
  - halted=0 in PAUSE.
- SEQ_SINGLE_STEP_EN undefined:
  - PAUSE is not generated and step is unused.
  - Throughput is the back-to-back 3-cycle flow.

## Structure
- Shared package cpu_pkg holds:
  - state enum (FETCH_OP, FETCH_ARG, EXEC, HALTED, PAUSE)
  - OP_SYS=4'hF
  - sub-op constants SYS_NOP, SYS_HALT, SYS_JMP, SYS_JZ
- One sub-module, instr_decode: purely combinational, maps op/arg plus zero to the EXEC control vector.
- FSM, op/arg registers and counter stay in instr_sequencer.

## Test plan
- Reset, then memRdy=1 with program 8'h12,8'h03 (aluSel 1, dest r2, src r3) → EXEC on cycle 3 with rInEn=1, rOutEn=1, genConst=0, aluSel=1, rInSel=2, rOutSel=3; instrCount=1.
- Constant op 8'h2D,8'h05 → genConst=1, rOutEn=0, rOutSel=5, rInSel=5.
- JMP 8'hF2,8'h40 → pcLoad=1, pcLoadVal=8'h40 in EXEC, pcInc=0 that cycle. JZ 8'hF3,8'h20 with zero=0 → pcLoad=0; with zero=1 → pcLoad=1, pcLoadVal=8'h20.
- memRdy low for 4 cycles during FETCH_ARG → memRd stays 1, no pcInc, EXEC delayed 4 cycles, arg = byte presented on the ready cycle.
- HALT 8'hF1 → halted=1, memRd=0 indefinitely. Reset mid-EXEC → all outputs reset asynchronously. 256 NOPs → instrCount wraps to 0.
- With SEQ_SINGLE_STEP_EN: after each EXEC the block idles in PAUSE with memRd=0; one step pulse → next fetch begins.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control path.
//   seqState_t  - instruction sequencer FSM states
//   OP_SYS      - op[7:4] value selecting the system instruction class
//   SYS_*       - system sub-op codes carried in op[2:0]
// PAUSE is only reachable when SEQ_SINGLE_STEP_EN is defined.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_ARG,
        EXEC,
        HALTED,
        PAUSE
    } seqState_t;

    localparam logic [3:0] OP_SYS   = 4'hF;

    localparam logic [2:0] SYS_NOP  = 3'b000;
    localparam logic [2:0] SYS_HALT = 3'b001;
    localparam logic [2:0] SYS_JMP  = 3'b010;
    localparam logic [2:0] SYS_JZ   = 3'b011;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of a latched two-byte instruction into the
// control vector used during the EXEC cycle. Enables are unconditional here;
// the sequencer gates them with its EXEC state.
// Ports:
//   op        in  8  instruction byte 0
//   arg       in  8  instruction byte 1
//   zero      in  1  ALU zero flag (for JZ)
//   aluSel    out 4  ALU operation (op[7:4])
//   rInSel    out 3  destination register (op[2:0])
//   rOutSel   out 3  source register / constant (arg[2:0])
//   pcLoadVal out 8  jump target (arg)
//   rInEn, rOutEn, genConst, pcLoad  out 1  decoded enables
//   isHalt    out 1  instruction is HALT
module instr_decode
    import cpu_pkg::*;
(
    input  logic [7:0] op,
    input  logic [7:0] arg,
    input  logic       zero,
    output logic [3:0] aluSel,
    output logic [2:0] rInSel,
    output logic [2:0] rOutSel,
    output logic [7:0] pcLoadVal,
    output logic       rInEn,
    output logic       rOutEn,
    output logic       genConst,
    output logic       pcLoad,
    output logic       isHalt
);

    assign aluSel    = op[7:4];
    assign rInSel    = op[2:0];
    assign rOutSel   = arg[2:0];
    assign pcLoadVal = arg;

    always_comb begin
        rInEn    = 1'b0;
        rOutEn   = 1'b0;
        genConst = 1'b0;
        pcLoad   = 1'b0;
        isHalt   = 1'b0;
        if (op[7:4] != OP_SYS) begin
            // op[3] picks constant drive over register read, so the two never coincide
            rInEn    = 1'b1;
            rOutEn   = ~op[3];
            genConst = op[3];
        end else begin
            case (op[2:0])
                SYS_HALT: isHalt = 1'b1;
                SYS_JMP:  pcLoad = 1'b1;
                SYS_JZ:   pcLoad = zero;
                default:  ; // NOP and reserved 1xx sub-ops
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit CPU.
// Fetches op and arg bytes through a memRd/memRdy handshake, then spends one
// EXEC cycle driving register-file, ALU and PC-load controls.
// Build option: SEQ_SINGLE_STEP_EN adds a PAUSE state after every non-HALT
// EXEC, left on a step pulse.
// Ports:
//   clk, rst (async, active-low)
//   memRd out / memRdy in / memVal in[8]     fetch handshake
//   pcInc out, pcLoad out, pcLoadVal out[8]  program counter control
//   zero in                                  ALU zero flag for JZ
//   aluSel out[4], rInSel out[3], rOutSel out[3]
//   rInEn, rOutEn, genConst out              register-file enables
//   step in                                  single-step advance
//   halted out, instrCount out[8]            status
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       memRd,
    input  logic       memRdy,
    input  logic [7:0] memVal,
    output logic       pcInc,
    output logic       pcLoad,
    output logic [7:0] pcLoadVal,
    input  logic       zero,
    output logic [3:0] aluSel,
    output logic [2:0] rInSel,
    output logic [2:0] rOutSel,
    output logic       rInEn,
    output logic       rOutEn,
    output logic       genConst,
    input  logic       step,
    output logic       halted,
    output logic [7:0] instrCount
);

    seqState_t  stateQ, stateD;
    logic [7:0] opQ, argQ;
    logic [7:0] countQ;
    logic       accept;

    logic decRInEn, decROutEn, decGenConst, decPcLoad, decHalt;

    instr_decode uDecode (
        .op        (opQ),
        .arg       (argQ),
        .zero      (zero),
        .aluSel    (aluSel),
        .rInSel    (rInSel),
        .rOutSel   (rOutSel),
        .pcLoadVal (pcLoadVal),
        .rInEn     (decRInEn),
        .rOutEn    (decROutEn),
        .genConst  (decGenConst),
        .pcLoad    (decPcLoad),
        .isHalt    (decHalt)
    );

    assign accept     = memRd & memRdy;
    assign pcInc      = accept;
    assign instrCount = countQ;

`ifndef SEQ_SINGLE_STEP_EN
    logic unusedStep;
    assign unusedStep = step;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= FETCH_OP;
            opQ    <= 8'h00;
            argQ   <= 8'h00;
            countQ <= 8'h00;
        end else begin
            stateQ <= stateD;
            if (accept && stateQ == FETCH_OP) begin
                opQ <= memVal;
            end
            if (accept && stateQ == FETCH_ARG) begin
                argQ <= memVal;
            end
            if (stateQ == EXEC) begin
                countQ <= countQ + 8'd1;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            FETCH_OP:  if (memRdy) stateD = FETCH_ARG;
            FETCH_ARG: if (memRdy) stateD = EXEC;
`ifdef SEQ_SINGLE_STEP_EN
            EXEC:      stateD = decHalt ? HALTED : PAUSE;
            PAUSE:     if (step) stateD = FETCH_OP;
`else
            EXEC:      stateD = decHalt ? HALTED : FETCH_OP;
`endif
            HALTED:    stateD = HALTED;
            default:   stateD = FETCH_OP;
        endcase
    end

    // Enables exist only in EXEC, so pcLoad can never overlap a fetch pcInc.
    always_comb begin
        memRd    = 1'b0;
        halted   = 1'b0;
        rInEn    = 1'b0;
        rOutEn   = 1'b0;
        genConst = 1'b0;
        pcLoad   = 1'b0;
        case (stateQ)
            FETCH_OP, FETCH_ARG: memRd = 1'b1;
            EXEC: begin
                rInEn    = decRInEn;
                rOutEn   = decROutEn;
                genConst = decGenConst;
                pcLoad   = decPcLoad;
            end
            HALTED:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a transaction-level model tracks accepted bytes,
// pending execute, halt and pause; a negedge process compares every output
// against it, and directed vectors add hand-computed literal expectations.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memRdy = 1'b0;
    logic [7:0] memVal = 8'h00;
    logic       zero = 1'b0;
    logic       step = 1'b0;

    logic       memRd, pcInc, pcLoad, rInEn, rOutEn, genConst, halted;
    logic [7:0] pcLoadVal, instrCount;
    logic [3:0] aluSel;
    logic [2:0] rInSel, rOutSel;

    instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .memRd      (memRd),
        .memRdy     (memRdy),
        .memVal     (memVal),
        .pcInc      (pcInc),
        .pcLoad     (pcLoad),
        .pcLoadVal  (pcLoadVal),
        .zero       (zero),
        .aluSel     (aluSel),
        .rInSel     (rInSel),
        .rOutSel    (rOutSel),
        .rInEn      (rInEn),
        .rOutEn     (rOutEn),
        .genConst   (genConst),
        .step       (step),
        .halted     (halted),
        .instrCount (instrCount)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endfunction

    // Model: which byte is wanted next, whether an instruction is executing,
    // halted/paused flags, the latched bytes and the retired count.
    bit         mHaveOp, mExec, mHalted, mPaused;
    logic [7:0] mOp, mArg;
    int         mCount;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mHaveOp <= 1'b0;
            mExec   <= 1'b0;
            mHalted <= 1'b0;
            mPaused <= 1'b0;
            mOp     <= 8'h00;
            mArg    <= 8'h00;
            mCount  <= 0;
        end else if (mHalted) begin
            mHalted <= 1'b1;
        end else if (mPaused) begin
            if (step) mPaused <= 1'b0;
        end else if (mExec) begin
            mCount <= (mCount + 1) % 256;
            mExec  <= 1'b0;
            if (mOp[7:4] == 4'hF && mOp[2:0] == 3'd1) begin
                mHalted <= 1'b1;
            end else begin
`ifdef SEQ_SINGLE_STEP_EN
                mPaused <= 1'b1;
`endif
            end
        end else if (memRdy) begin
            if (!mHaveOp) begin
                mOp     <= memVal;
                mHaveOp <= 1'b1;
            end else begin
                mArg    <= memVal;
                mHaveOp <= 1'b0;
                mExec   <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            bit eRd, sys, alu;
            eRd = !mHalted && !mExec && !mPaused;
            sys = (mOp[7:4] == 4'hF);
            alu = !sys;
            check("memRd", int'(memRd), int'(eRd));
            check("pcInc", int'(pcInc), int'(eRd && memRdy));
            check("halted", int'(halted), int'(mHalted));
            check("instrCount", int'(instrCount), mCount);
            check("aluSel", int'(aluSel), int'(mOp[7:4]));
            check("rInSel", int'(rInSel), int'(mOp[2:0]));
            check("rOutSel", int'(rOutSel), int'(mArg[2:0]));
            check("pcLoadVal", int'(pcLoadVal), int'(mArg));
            check("rInEn", int'(rInEn), int'(mExec && alu));
            check("rOutEn", int'(rOutEn), int'(mExec && alu && !mOp[3]));
            check("genConst", int'(genConst), int'(mExec && alu && mOp[3]));
            check("pcLoad", int'(pcLoad),
                  int'(mExec && sys && (mOp[2:0] == 3'd2 || (mOp[2:0] == 3'd3 && zero))));
        end
    end

    task automatic fetchByte(input logic [7:0] b, input int waits);
        for (int i = 0; i < waits; i++) begin
            memRdy = 1'b0;
            memVal = 8'hA5 ^ 8'(i);
            @(posedge clk); #1;
        end
        memRdy = 1'b1;
        memVal = b;
        @(posedge clk); #1;
    endtask

    // Returns at the negedge inside the EXEC cycle; memRdy/step held high to
    // show they are ignored there.
    task automatic startInstr(input logic [7:0] op, input logic [7:0] arg,
                              input int wOp, input int wArg, input logic z);
        fetchByte(op, wOp);
        fetchByte(arg, wArg);
        memRdy = 1'b1;
        memVal = 8'hEE;
        zero   = z;
        step   = 1'b1;
        @(negedge clk);
    endtask

    task automatic endInstr(input bit isHalt);
        step = 1'b0;
        @(posedge clk); #1;
`ifdef SEQ_SINGLE_STEP_EN
        if (!isHalt) begin
            memRdy = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            check("pauseMemRd", int'(memRd), 0);
            step = 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
            check("stepResume", int'(memRd), 1);
        end
`else
        if (isHalt) step = 1'b0;
`endif
    endtask

    task automatic runInstr(input logic [7:0] op, input logic [7:0] arg);
        startInstr(op, arg, 0, 0, 1'b0);
        endInstr(op[7:4] == 4'hF && op[2:0] == 3'd1);
    endtask

    task automatic doReset();
        rst = 1'b0;
        memRdy = 1'b0;
        step = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        doReset();
        @(negedge clk);
        check("resetMemRd", int'(memRd), 1);
        check("resetCount", int'(instrCount), 0);
        check("resetHalted", int'(halted), 0);
        @(posedge clk); #1;

        // ALU register op: aluSel 1, dest r2, src r3
        startInstr(8'h12, 8'h03, 0, 0, 1'b0);
        check("alu_rInEn", int'(rInEn), 1);
        check("alu_rOutEn", int'(rOutEn), 1);
        check("alu_genConst", int'(genConst), 0);
        check("alu_aluSel", int'(aluSel), 1);
        check("alu_rInSel", int'(rInSel), 2);
        check("alu_rOutSel", int'(rOutSel), 3);
        endInstr(1'b0);
        check("alu_count", int'(instrCount), 1);

        // constant-drive op
        startInstr(8'h2D, 8'h05, 0, 0, 1'b0);
        check("const_genConst", int'(genConst), 1);
        check("const_rOutEn", int'(rOutEn), 0);
        check("const_rOutSel", int'(rOutSel), 5);
        check("const_rInSel", int'(rInSel), 5);
        endInstr(1'b0);

        // JMP with memRdy high in EXEC
        startInstr(8'hF2, 8'h40, 0, 0, 1'b0);
        check("jmp_pcLoad", int'(pcLoad), 1);
        check("jmp_target", int'(pcLoadVal), 8'h40);
        check("jmp_pcInc", int'(pcInc), 0);
        endInstr(1'b0);

        // JZ not taken / taken
        startInstr(8'hF3, 8'h20, 0, 0, 1'b0);
        check("jz0_pcLoad", int'(pcLoad), 0);
        endInstr(1'b0);
        startInstr(8'hF3, 8'h20, 1, 0, 1'b1);
        check("jz1_pcLoad", int'(pcLoad), 1);
        check("jz1_target", int'(pcLoadVal), 8'h20);
        endInstr(1'b0);

        // four wait states on the arg byte
        startInstr(8'h34, 8'h07, 0, 4, 1'b0);
        check("wait_rOutSel", int'(rOutSel), 7);
        check("wait_rInEn", int'(rInEn), 1);
        endInstr(1'b0);
        check("wait_count", int'(instrCount), 6);

        // reserved sub-op 1xx behaves as NOP
        startInstr(8'hF5, 8'h00, 0, 0, 1'b1);
        check("rsv_rInEn", int'(rInEn), 0);
        check("rsv_pcLoad", int'(pcLoad), 0);
        endInstr(1'b0);

        // reset in the middle of EXEC
        startInstr(8'h9A, 8'h06, 0, 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rstExec_rInEn", int'(rInEn), 0);
        check("rstExec_rOutEn", int'(rOutEn), 0);
        check("rstExec_count", int'(instrCount), 0);
        check("rstExec_aluSel", int'(aluSel), 0);
        check("rstExec_rOutSel", int'(rOutSel), 0);
        check("rstExec_halted", int'(halted), 0);
        step = 1'b0;
        memRdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // 256 NOPs wrap the counter
        for (int n = 0; n < 256; n++) begin
            runInstr(8'hF0, 8'h00);
            if (n == 254) check("count255", int'(instrCount), 255);
        end
        check("countWrap", int'(instrCount), 0);

        // HALT: terminal, memory requests ignored
        runInstr(8'hF1, 8'h00);
        memRdy = 1'b1;
        step = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("halt_halted", int'(halted), 1);
        check("halt_memRd", int'(memRd), 0);
        check("halt_count", int'(instrCount), 1);
        step = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
